// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, MEM-stage branch flush and a
// drain/halt sequence triggered by an all-zero instruction in IF/ID.

module hazard_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (inc && (cnt != '1))   cnt <= cnt + 1'b1;  // saturate, never wrap
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             id_valid_i,
  input  logic [31:0]      id_instr_i,
  input  logic             ex_memrd_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_pcsrc_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o,
  output logic             halted_o
);
  localparam int NUM_CNT = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctl_t;

  state_t state, state_nxt;
  logic [1:0] drain_cnt, drain_cnt_nxt;
  ctl_t ctl;
  logic load_use;
  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;

  assign load_use = id_valid_i && ex_memrd_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_instr_i[19:15]) || (ex_rd_i == id_instr_i[24:20]));

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state     <= IDLE;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    ctl           = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                      id_ex_flush: 1'b1, ex_mem_flush: 1'b1};
    cnt_inc       = '0;
    unique case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (mem_pcsrc_i) begin
          // taken branch squashes everything younger, including a pending stall
          ctl        = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
          cnt_inc[1] = 1'b1;
        end else if (load_use) begin
          ctl        = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
          cnt_inc[0] = 1'b1;
        end else begin
          ctl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
          if (id_valid_i && (id_instr_i == 32'd0)) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = 2'd3;
          end
        end
      end
      DRAIN: begin
        if (mem_pcsrc_i) begin
          // branch is older than the drain marker: resume normal flow
          ctl           = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
          cnt_inc[1]    = 1'b1;
          state_nxt     = RUN;
          drain_cnt_nxt = 2'd0;
        end else begin
          ctl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
          if (drain_cnt == 2'd0) state_nxt = HALT;
          else                   drain_cnt_nxt = drain_cnt - 2'd1;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CNT; k++) begin : g_cnt
      hazard_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_n (start_i),
        .inc   (cnt_inc[k]),
        .cnt   (cnt[k])
      );
    end
  endgenerate

  assign stall_cnt_o    = cnt[0];
  assign flush_cnt_o    = cnt[1];
  assign pc_write_o     = ctl.pc_write;
  assign if_id_write_o  = ctl.if_id_write;
  assign if_id_flush_o  = ctl.if_id_flush;
  assign id_ex_flush_o  = ctl.id_ex_flush;
  assign ex_mem_flush_o = ctl.ex_mem_flush;
  assign state_o        = state;
  assign halted_o       = (state == HALT);
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1: sole clock; all state changes on rising edge.
REQ-002 SHALL have port start_i, input, 1: asynchronous active-low reset; low clears all state immediately, high enables operation.
REQ-003 SHALL have port id_valid_i, input, 1: IF/ID register holds a valid instruction.
REQ-004 SHALL have port id_instr_i, input, 32: instruction word in IF/ID.
REQ-005 SHALL have port ex_memrd_i, input, 1: instruction in ID/EX is a load.
REQ-006 SHALL have port ex_rd_i, input, 5: destination register in ID/EX.
REQ-007 SHALL have port mem_pcsrc_i, input, 1: branch taken, resolved in MEM stage.
REQ-008 SHALL have port pc_write_o, output, 1: PC update enable.
REQ-009 SHALL have port if_id_write_o, output, 1: IF/ID load enable.
REQ-010 SHALL have port if_id_flush_o, output, 1: zero IF/ID (valid=0) next edge.
REQ-011 SHALL have port id_ex_flush_o, output, 1: zero ID/EX control bits next edge.
REQ-012 SHALL have port ex_mem_flush_o, output, 1: zero EX/MEM control bits next edge.
REQ-013 SHALL have port stall_cnt_o, output, 32: load-use stall cycle count.
REQ-014 SHALL have port flush_cnt_o, output, 32: branch flush event count.
REQ-015 SHALL have port state_o, output, 2: FSM state (IDLE=0, RUN=1, DRAIN=2, HALT=3).
REQ-016 SHALL have port halted_o, output, 1: high exactly when state is HALT.

Function
REQ-017 SHALL implement FSM IDLE->RUN on first rising edge with start_i high.
REQ-018 SHALL, in IDLE, drive pc_write_o=0, if_id_write_o=0, all flushes=1.
REQ-019 SHALL, in RUN, detect load-use combinationally: id_valid_i & ex_memrd_i & ex_rd_i!=0 & (ex_rd_i==id_instr_i[19:15] | ex_rd_i==id_instr_i[24:20]).
REQ-020 SHALL, on load-use without mem_pcsrc_i, drive pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1 for that cycle only; stall_cnt_o +1 next edge.
REQ-021 SHALL, when mem_pcsrc_i=1 in RUN or DRAIN, drive if_id_flush_o, id_ex_flush_o, ex_mem_flush_o=1, pc_write_o=1; flush_cnt_o +1 next edge; stall suppressed, not counted.
REQ-022 SHALL, in RUN with id_valid_i=1, id_instr_i==0 and no mem_pcsrc_i/load-use, enter DRAIN with 2-bit drain counter loaded to 3.
REQ-023 SHALL, in DRAIN, hold pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, decrement counter each cycle; at 0 enter HALT next edge.
REQ-024 SHALL, on mem_pcsrc_i=1 in DRAIN, return to RUN next edge (branch older than drain marker).
REQ-025 SHALL, in HALT, keep pc_write_o=0, if_id_write_o=0, all flushes=1; remain until reset.
REQ-026 SHALL saturate both counters at 32'hFFFFFFFF (no wrap).
REQ-027 SHALL, otherwise in RUN, drive pc_write_o=1, if_id_write_o=1, flushes=0.

Reset
REQ-028 SHALL, on start_i low at any time including mid-stall/DRAIN, force state IDLE, counters 0, drain counter 0, halted_o 0, outputs per REQ-018.

Verification
REQ-029 Reset then start_i high -> state_o 0 then 1 after one edge; counters 0.
REQ-030 ex_memrd_i=1, ex_rd_i=5, id_instr_i rs1=5, id_valid_i=1 one cycle -> pc_write_o=0, id_ex_flush_o=1 that cycle; stall_cnt_o=1.
REQ-031 Same load-use plus mem_pcsrc_i=1 -> all three flushes=1, pc_write_o=1; flush_cnt_o=1, stall_cnt_o=0.
REQ-032 id_instr_i=0 valid in RUN -> DRAIN 4 cycles, then state_o=3, halted_o=1; mem_pcsrc_i mid-DRAIN -> RUN.
REQ-033 start_i low during DRAIN -> immediate IDLE, counters 0, halted_o 0.
REQ-034 ex_rd_i=0 with matching rs1=0 load -> no stall.
